// File: rtl/rv32_defines_pkg.sv
// Shared RV32I front-end definitions.
// Fetch FSM encodings and reset constants.
package rv32_defines_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: PC, request FSM, one-entry buffer.
// Redirects flush the buffer and squash any in-flight fetch.
module instr_fetch_unit
  import rv32_defines_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv32_defines_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_defines_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         misal_q, misal_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    misal_d    = misal_q;
    if (state_q == FS_HALT) begin
      state_d = FS_HALT;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        misal_d    = 1'b1;
        if_valid_d = 1'b0;
        state_d    = FS_HALT;
      end else begin
        unique case (state_q)
          FS_REQ: begin
            // old address already accepted: squash its response
            if (imem_req_ready) begin
              state_d = FS_WAIT;
              drop_d  = 1'b1;
            end
          end
          FS_WAIT: begin
            if (imem_rsp_valid) begin
              state_d = FS_REQ;
              drop_d  = 1'b0;
            end else begin
              drop_d = 1'b1;
            end
          end
          FS_HOLD: begin
            if_valid_d = 1'b0;
            state_d    = FS_REQ;
          end
          default: ;
        endcase
      end
    end else begin
      unique case (state_q)
        FS_REQ: begin
          if (imem_req_ready) state_d = FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FS_REQ;
            end else begin
              if_instr_d = imem_rsp_data;
              if_pc_d    = pc_q;
              pc_d       = pc_q + 32'd4;
              if_valid_d = 1'b1;
              state_d    = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (if_ready) begin
            if_valid_d = 1'b0;
            state_d    = FS_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      misal_q    <= misal_d;
    end
  end

  assign imem_req_valid   = rst_n && (state_q == FS_REQ);
  assign imem_req_addr    = pc_q;
  assign if_valid         = if_valid_q;
  assign if_instr         = if_instr_q;
  assign if_pc            = if_pc_q;
  assign if_pc_plus4      = if_pc_q + 32'd4;
  assign fetch_misaligned = misal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level
// model (outstanding/stale/buffer flags) and a reactive memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_misaligned;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h1357_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: fetch stream as flags rather than an FSM
  logic [31:0] m_pc = 32'h0;
  logic        m_out = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_buf = 1'b0;
  logic [31:0] m_instr = 32'h13;
  logic [31:0] m_ipc = 32'h0;
  logic        m_halt = 1'b0;
  logic        m_misal = 1'b0;
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic m_req();
    return !m_halt && !m_out && !m_buf;
  endfunction

  initial begin
    forever begin
      logic rv, rdy, rsv, ifr, req, out0;
      logic [31:0] rp, rsd;
      @(posedge clk);
      rv = redirect_valid; rp = redirect_pc; rdy = imem_req_ready;
      rsv = imem_rsp_valid; rsd = imem_rsp_data; ifr = if_ready;
      if (!rst_n) begin
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_buf = 0;
        m_instr = 32'h13; m_ipc = 32'h0; m_halt = 0; m_misal = 0;
        mem_pend = 0;
      end else begin
        req = m_req();
        out0 = m_out;
        if (req && rdy) begin
          mem_pend = 1; mem_cnt = mem_lat; mem_addr = m_pc;
        end
        if (m_halt) begin
        end else if (rv) begin
          m_pc = rp;
          m_buf = 0;
          if (rp[1:0] != 2'b00) begin
            m_halt = 1; m_misal = 1; m_out = 0;
          end else if (req && rdy) begin
            m_out = 1; m_stale = 1;
          end else if (out0 && rsv) begin
            m_out = 0; m_stale = 0;
          end else if (out0) begin
            m_stale = 1;
          end
        end else if (req && rdy) begin
          m_out = 1;
        end else if (out0 && rsv) begin
          m_out = 0;
          if (m_stale) m_stale = 0;
          else begin
            m_buf = 1; m_instr = rsd; m_ipc = m_pc; m_pc = m_pc + 4;
          end
        end else if (m_buf && ifr) begin
          m_buf = 0;
        end
      end
      #1;
      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = memfn(mem_addr);
          mem_pend = 0;
        end else mem_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req()});
      chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_buf});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc_plus4", if_pc_plus4, m_ipc + 32'd4);
      chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, m_misal});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ifv();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_valid) return;
    end
    chk("wait_if_valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req_valid) return;
    end
    chk("wait_req_timeout", 32'h0, 32'h1);
  endtask

  task automatic consume();
    step(); if_ready = 1'b1; imem_req_ready = 1'b0;
    step(); if_ready = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_misal", {31'b0, fetch_misaligned}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    wait_ifv();
    chk("first_instr", if_instr, 32'h0050_0093);
    chk("first_pc", if_pc, 32'h0);
    chk("first_pc4", if_pc_plus4, 32'h4);
    // memory stall on the second request
    consume();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("stall_req_addr", imem_req_addr, 32'h4);
    end
    step(); imem_req_ready = 1'b1;
    wait_ifv();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_if_pc", if_pc, 32'h4);
      chk("hold_if_instr", if_instr, 32'h4 ^ 32'h1357_0013);
      chk("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
    end
    consume();
    // redirect while waiting for 0x200
    step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_req_addr", imem_req_addr, 32'h200);
    step(); mem_lat = 3; imem_req_ready = 1'b1;
    step(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h210;
    step(); redirect_valid = 1'b0;
    wait_req();
    chk("drop_req_addr", imem_req_addr, 32'h210);
    chk("drop_if_valid", {31'b0, if_valid}, 32'h0);
    // redirect coincident with response
    mem_lat = 2;
    step(); imem_req_ready = 1'b1;
    step(); imem_req_ready = 1'b0;
    step(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("rsp_redir_req", {31'b0, imem_req_valid}, 32'h1);
    chk("rsp_redir_addr", imem_req_addr, 32'h100);
    chk("rsp_redir_ifv", {31'b0, if_valid}, 32'h0);
    // redirect coincident with acceptance
    mem_lat = 1;
    step(); imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h1008;
    step(); imem_req_ready = 1'b0; redirect_valid = 1'b0;
    wait_req();
    chk("acc_redir_addr", imem_req_addr, 32'h1008);
    chk("acc_redir_ifv", {31'b0, if_valid}, 32'h0);
    step(); imem_req_ready = 1'b1;
    wait_ifv();
    chk("acc_redir_pc", if_pc, 32'h1008);
    chk("acc_redir_instr", if_instr, 32'h1008 ^ 32'h1357_0013);
    consume();
    // wrap-around
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    wait_ifv();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    consume();
    @(negedge clk);
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    // misaligned redirect halts the unit
    step(); redirect_valid = 1'b1; redirect_pc = 32'h1002;
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    chk("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
    chk("mis_no_req", {31'b0, imem_req_valid}, 32'h0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_no_req", {31'b0, imem_req_valid}, 32'h0);
      chk("halt_flag", {31'b0, fetch_misaligned}, 32'h1);
      chk("halt_ifv", {31'b0, if_valid}, 32'h0);
    end
    step(); rst_n = 1'b0;
    #1;
    chk("rerst_misal", {31'b0, fetch_misaligned}, 32'h0);
    chk("rerst_req", {31'b0, imem_req_valid}, 32'h0);
    step(); step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("rerst_req_addr", imem_req_addr, 32'h0);
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
